model_matrix_vector_product: RTL and testbench

Streaming matrix-vector product y = A·b for the NTM math library.
- Buffers vector b internally, then consumes matrix A row-major, one element per handshake, and emits one result element per completed row.
- Sits directly upstream of the matrix tanh stage and produces the pre-activation stream W·x. Its output is consumed as an I×1 matrix (SIZE_J = 1) by model_matrix_tanh_function.

---
 rtl/model_matrix_vector_product.sv | 166 ++++++++++++++++
 tb/tb_model_matrix_vector_product.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/model_matrix_vector_product.sv
// Streaming y = A*b: buffers b, then consumes A row-major one element per handshake
// and emits one y element per completed row. Unsigned, modulo 2^DATA_SIZE arithmetic.
module model_matrix_vector_product #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int MAX_SIZE     = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  output logic                 ERROR,
  input  logic                 DATA_B_IN_ENABLE,
  input  logic                 DATA_A_IN_I_ENABLE,
  input  logic                 DATA_A_IN_J_ENABLE,
  output logic                 DATA_B_ENABLE,
  output logic                 DATA_I_ENABLE,
  output logic                 DATA_J_ENABLE,
  output logic                 DATA_OUT_ENABLE,
  input  logic [DATA_SIZE-1:0] SIZE_A_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_A_J_IN,
  input  logic [DATA_SIZE-1:0] SIZE_B_IN,
  input  logic [DATA_SIZE-1:0] DATA_A_IN,
  input  logic [DATA_SIZE-1:0] DATA_B_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  localparam int ADDR_W = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;

  localparam logic [1:0] STARTER    = 2'd0;
  localparam logic [1:0] INPUT_B    = 2'd1;
  localparam logic [1:0] INPUT_A    = 2'd2;
  localparam logic [1:0] ACCUMULATE = 2'd3;

  logic [1:0]              state_r;
  logic [DATA_SIZE-1:0]    size_i_r;
  logic [DATA_SIZE-1:0]    size_j_r;
  logic [DATA_SIZE-1:0]    size_b_r;
  logic [CONTROL_SIZE-1:0] index_i_r;
  logic [CONTROL_SIZE-1:0] index_j_r;
  logic [CONTROL_SIZE-1:0] index_b_r;
  logic [DATA_SIZE-1:0]    acc_r;
  logic [DATA_SIZE-1:0]    prod_r;
  logic [DATA_SIZE-1:0]    buffer_r [MAX_SIZE];

  logic                    sizes_legal_s;
  logic                    last_b_s;
  logic                    last_j_s;
  logic                    last_i_s;
  logic                    a_accept_s;
  logic [ADDR_W-1:0]       b_addr_s;
  logic [ADDR_W-1:0]       j_addr_s;
  logic [DATA_SIZE-1:0]    acc_next_s;

  // Size legality, end-of-loop flags and the running sum for the current element.
  always_comb begin
    sizes_legal_s = (SIZE_A_I_IN != '0) && (SIZE_B_IN != '0) &&
                    (SIZE_B_IN <= DATA_SIZE'(MAX_SIZE)) && (SIZE_A_J_IN == SIZE_B_IN);
    last_b_s      = (index_b_r == CONTROL_SIZE'(size_b_r - {{(DATA_SIZE-1){1'b0}}, 1'b1}));
    last_j_s      = (index_j_r == CONTROL_SIZE'(size_j_r - {{(DATA_SIZE-1){1'b0}}, 1'b1}));
    last_i_s      = (index_i_r == CONTROL_SIZE'(size_i_r - {{(DATA_SIZE-1){1'b0}}, 1'b1}));
    a_accept_s    = DATA_A_IN_I_ENABLE | DATA_A_IN_J_ENABLE;
    b_addr_s      = index_b_r[ADDR_W-1:0];
    j_addr_s      = index_j_r[ADDR_W-1:0];
    if (index_j_r == '0) begin
      acc_next_s = prod_r;
    end else begin
      acc_next_s = acc_r + prod_r;
    end
  end

  // b buffer storage; deliberately not reset, every run reloads it before use.
  always_ff @(posedge CLK) begin
    if (state_r == INPUT_B && DATA_B_IN_ENABLE) begin
      buffer_r[b_addr_s] <= DATA_B_IN;
    end
  end

  // Control FSM, index counters, datapath registers and registered output pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r         <= STARTER;
      size_i_r        <= '0;
      size_j_r        <= '0;
      size_b_r        <= '0;
      index_i_r       <= '0;
      index_j_r       <= '0;
      index_b_r       <= '0;
      acc_r           <= '0;
      prod_r          <= '0;
      READY           <= 1'b0;
      ERROR           <= 1'b0;
      DATA_B_ENABLE   <= 1'b0;
      DATA_I_ENABLE   <= 1'b0;
      DATA_J_ENABLE   <= 1'b0;
      DATA_OUT_ENABLE <= 1'b0;
      DATA_OUT        <= '0;
    end else begin
      READY           <= 1'b0;
      ERROR           <= 1'b0;
      DATA_B_ENABLE   <= 1'b0;
      DATA_I_ENABLE   <= 1'b0;
      DATA_J_ENABLE   <= 1'b0;
      DATA_OUT_ENABLE <= 1'b0;
      case (state_r)
        STARTER: begin
          if (START) begin
            if (sizes_legal_s) begin
              size_i_r  <= SIZE_A_I_IN;
              size_j_r  <= SIZE_A_J_IN;
              size_b_r  <= SIZE_B_IN;
              index_i_r <= '0;
              index_j_r <= '0;
              index_b_r <= '0;
              acc_r     <= '0;
              state_r   <= INPUT_B;
            end else begin
              ERROR <= 1'b1;
            end
          end
        end
        INPUT_B: begin
          if (DATA_B_IN_ENABLE) begin
            if (last_b_s) begin
              state_r <= INPUT_A;
            end else begin
              index_b_r     <= index_b_r + {{(CONTROL_SIZE-1){1'b0}}, 1'b1};
              DATA_B_ENABLE <= 1'b1;
            end
          end
        end
        INPUT_A: begin
          if (a_accept_s) begin
            prod_r  <= DATA_A_IN * buffer_r[j_addr_s];
            state_r <= ACCUMULATE;
          end
        end
        ACCUMULATE: begin
          acc_r <= acc_next_s;
          if (!last_j_s) begin
            index_j_r     <= index_j_r + {{(CONTROL_SIZE-1){1'b0}}, 1'b1};
            DATA_J_ENABLE <= 1'b1;
            state_r       <= INPUT_A;
          end else begin
            DATA_OUT        <= acc_next_s;
            DATA_OUT_ENABLE <= 1'b1;
            if (last_i_s) begin
              READY   <= 1'b1;
              state_r <= STARTER;
            end else begin
              index_i_r     <= index_i_r + {{(CONTROL_SIZE-1){1'b0}}, 1'b1};
              index_j_r     <= '0;
              DATA_I_ENABLE <= 1'b1;
              DATA_J_ENABLE <= 1'b1;
              state_r       <= INPUT_A;
            end
          end
        end
        default: begin
          state_r <= STARTER;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_model_matrix_vector_product.sv
// Lockstep bench for model_matrix_vector_product: directed cases plus random
// matrices, checked against a plain-arithmetic dot-product model.
module tb_model_matrix_vector_product;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        READY, ERROR;
  logic        DATA_B_IN_ENABLE = 1'b0;
  logic        DATA_A_IN_I_ENABLE = 1'b0;
  logic        DATA_A_IN_J_ENABLE = 1'b0;
  logic        DATA_B_ENABLE, DATA_I_ENABLE, DATA_J_ENABLE, DATA_OUT_ENABLE;
  logic [63:0] SIZE_A_I_IN = 64'd0;
  logic [63:0] SIZE_A_J_IN = 64'd0;
  logic [63:0] SIZE_B_IN = 64'd0;
  logic [63:0] DATA_A_IN = 64'd0;
  logic [63:0] DATA_B_IN = 64'd0;
  logic [63:0] DATA_OUT;

  logic [63:0] a_m [16][16];
  logic [63:0] b_v [16];
  int n_checks = 0;
  int n_pass = 0;

  model_matrix_vector_product dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .ERROR(ERROR),
    .DATA_B_IN_ENABLE(DATA_B_IN_ENABLE), .DATA_A_IN_I_ENABLE(DATA_A_IN_I_ENABLE),
    .DATA_A_IN_J_ENABLE(DATA_A_IN_J_ENABLE), .DATA_B_ENABLE(DATA_B_ENABLE),
    .DATA_I_ENABLE(DATA_I_ENABLE), .DATA_J_ENABLE(DATA_J_ENABLE),
    .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .SIZE_A_I_IN(SIZE_A_I_IN),
    .SIZE_A_J_IN(SIZE_A_J_IN), .SIZE_B_IN(SIZE_B_IN), .DATA_A_IN(DATA_A_IN),
    .DATA_B_IN(DATA_B_IN), .DATA_OUT(DATA_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] pulses();
    return {58'd0, READY, ERROR, DATA_B_ENABLE, DATA_I_ENABLE, DATA_J_ENABLE, DATA_OUT_ENABLE};
  endfunction

  // Reference: y[i] = sum_j A[i][j]*b[j], truncated to 64 bits.
  function automatic logic [63:0] model_y(input int i, input int nj);
    logic [63:0] y;
    y = 64'd0;
    for (int j = 0; j < nj; j++) y = y + a_m[i][j] * b_v[j];
    return y;
  endfunction

  task automatic run_op(input int ni, input int nj, input int gap,
                        input bit start_mid, input int abort_row);
    @(negedge CLK);
    START = 1'b1; SIZE_A_I_IN = 64'(ni); SIZE_A_J_IN = 64'(nj); SIZE_B_IN = 64'(nj);
    DATA_B_IN_ENABLE = 1'b1; DATA_B_IN = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge CLK);
    START = 1'b0; DATA_B_IN_ENABLE = 1'b0;
    check_eq("start_quiet", pulses(), 64'd0);
    for (int k = 0; k < nj; k++) begin
      repeat (gap) begin
        @(negedge CLK);
        check_eq("b_gap_quiet", pulses(), 64'd0);
      end
      DATA_B_IN_ENABLE = 1'b1; DATA_B_IN = b_v[k];
      @(negedge CLK);
      DATA_B_IN_ENABLE = 1'b0;
      check_eq($sformatf("b_req[%0d]", k), pulses(), (k < nj - 1) ? 64'd8 : 64'd0);
    end
    for (int i = 0; i < ni; i++) begin
      for (int j = 0; j < nj; j++) begin
        repeat (gap) begin
          @(negedge CLK);
          check_eq("a_gap_quiet", pulses(), 64'd0);
        end
        DATA_A_IN = a_m[i][j];
        DATA_A_IN_I_ENABLE = (j == 0);
        DATA_A_IN_J_ENABLE = (j != 0);
        if (start_mid && i == 0 && j == nj - 1) START = 1'b1;
        @(negedge CLK);
        DATA_A_IN_I_ENABLE = 1'b0; DATA_A_IN_J_ENABLE = 1'b0; START = 1'b0;
        check_eq("acc_quiet", pulses(), 64'd0);
        @(negedge CLK);
        if (j < nj - 1) begin
          check_eq($sformatf("j_req[%0d][%0d]", i, j), pulses(), 64'd2);
        end else begin
          check_eq($sformatf("y[%0d]", i), DATA_OUT, model_y(i, nj));
          check_eq($sformatf("row_end_pulses[%0d]", i), pulses(),
                   (i == ni - 1) ? 64'h21 : 64'h7);
          if (i == abort_row) begin
            RST = 1'b1;
            #1;
            check_eq("abort_pulses", pulses(), 64'd0);
            check_eq("abort_data_out", DATA_OUT, 64'd0);
            @(negedge CLK);
            RST = 1'b0;
            return;
          end
        end
      end
    end
    @(negedge CLK);
    check_eq("post_ready_quiet", pulses(), 64'd0);
    check_eq("data_out_hold", DATA_OUT, model_y(ni - 1, nj));
  endtask

  task automatic try_illegal(input int ni, input int nj, input int nb);
    @(negedge CLK);
    START = 1'b1; SIZE_A_I_IN = 64'(ni); SIZE_A_J_IN = 64'(nj); SIZE_B_IN = 64'(nb);
    @(negedge CLK);
    START = 1'b0;
    check_eq("illegal_error", pulses(), 64'h10);
    DATA_B_IN_ENABLE = 1'b1;
    @(negedge CLK);
    DATA_B_IN_ENABLE = 1'b0;
    check_eq("illegal_quiet", pulses(), 64'd0);
    @(negedge CLK);
    check_eq("illegal_stay", pulses(), 64'd0);
  endtask

  task automatic load_case1();
    a_m[0][0] = 64'd1; a_m[0][1] = 64'd2; a_m[1][0] = 64'd3; a_m[1][1] = 64'd4;
    b_v[0] = 64'd5; b_v[1] = 64'd6;
  endtask

  initial begin
    #2;
    check_eq("reset_pulses", pulses(), 64'd0);
    check_eq("reset_data_out", DATA_OUT, 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    load_case1();
    run_op(2, 2, 0, 1'b0, -1);
    check_eq("case1_y0_model", model_y(0, 2), 64'd17);

    a_m[0][0] = 64'h8000_0000_0000_0000; b_v[0] = 64'd2;
    run_op(1, 1, 0, 1'b0, -1);
    check_eq("wrap_zero", DATA_OUT, 64'd0);
    a_m[0][0] = 64'hFFFF_FFFF_FFFF_FFFF; b_v[0] = 64'd3;
    run_op(1, 1, 0, 1'b0, -1);
    check_eq("neg_one_times_3", DATA_OUT, 64'hFFFF_FFFF_FFFF_FFFD);

    try_illegal(2, 3, 2);
    try_illegal(2, 17, 17);
    try_illegal(0, 2, 2);

    load_case1();
    run_op(2, 2, 5, 1'b0, -1);
    check_eq("stall_y1", DATA_OUT, 64'd39);
    run_op(2, 2, 0, 1'b1, -1);
    check_eq("busy_y1", DATA_OUT, 64'd39);
    run_op(2, 2, 0, 1'b0, 0);
    a_m[0][0] = 64'd2; a_m[0][1] = 64'd0; a_m[1][0] = 64'd0; a_m[1][1] = 64'd2;
    b_v[0] = 64'd7; b_v[1] = 64'd9;
    run_op(2, 2, 0, 1'b0, -1);
    check_eq("after_reset_y1", DATA_OUT, 64'd18);

    for (int t = 0; t < 8; t++) begin
      int ni, nj;
      ni = int'($urandom_range(1, 4));
      nj = int'($urandom_range(1, 16));
      for (int j = 0; j < nj; j++) begin
        b_v[j] = {$urandom, $urandom};
        for (int i = 0; i < ni; i++) a_m[i][j] = {$urandom, $urandom};
      end
      run_op(ni, nj, int'($urandom_range(0, 2)), 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
